// File: rtl/twos_complement_pkg.sv
// Shared types and width-generic constants for the two's-complement negation unit.
package twos_complement_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_PASS    = 2'b00,
        OP_NEG     = 2'b01,
        OP_ABS     = 2'b10,
        OP_NEG_ALT = 2'b11
    } op_e;

    // Most-negative value of a w-bit signed word, right-aligned in MAX_WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] min_val(input int unsigned w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

    // Most-positive value of a w-bit signed word, right-aligned in MAX_WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] max_val(input int unsigned w);
        return min_val(w) - MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/twos_negate.sv
// Combinational two's-complement negate with most-negative operand detect.
module twos_negate
    import twos_complement_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] neg,
    output logic             is_min
);

    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_val(WIDTH));

    always_comb begin
        neg    = (~a) + WIDTH'(1);
        is_min = (a == MIN_VAL);
    end

endmodule

// File: rtl/twos_complement.sv
// Registered PASS/NEG/ABS unit with zero/overflow flags, one-cycle latency.
// Define TWOS_COMPLEMENT_SAT_EN to saturate NEG/ABS of the most-negative value to max positive.
module twos_complement
    import twos_complement_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] neg;
    logic             is_min;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] data_out_d, data_out_q;
    logic             zero_d, zero_q;
    logic             ovf_d, ovf_q;

    logic [WIDTH-1:0] result;
    logic             result_ovf;

    twos_negate #(.WIDTH(WIDTH)) u_negate (
        .a      (data_in),
        .neg    (neg),
        .is_min (is_min)
    );

    // Opcode select and optional saturation of the single unrepresentable case.
    always_comb begin
        result     = data_in;
        result_ovf = 1'b0;
        unique case (op_e'(op))
            OP_PASS: begin
                result     = data_in;
                result_ovf = 1'b0;
            end
            OP_NEG, OP_NEG_ALT: begin
                result     = neg;
                result_ovf = is_min;
            end
            OP_ABS: begin
                if (data_in[WIDTH-1]) begin
                    result     = neg;
                    result_ovf = is_min;
                end
            end
        endcase
`ifdef TWOS_COMPLEMENT_SAT_EN
        if (result_ovf) begin
            result = MAX_VAL;
        end
`endif
    end

    // Result registers load only on valid input; flags follow the final data.
    always_comb begin
        out_valid_d = in_valid;
        data_out_d  = data_out_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        if (in_valid) begin
            data_out_d = result;
            zero_d     = (result == '0);
            ovf_d      = result_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

`ifndef TWOS_COMPLEMENT_SAT_EN
    logic unused_max;
    assign unused_max = ^MAX_VAL;
`endif

endmodule

// File: tb/tb_twos_complement.sv
// Self-checking bench for twos_complement: directed test-plan cases plus randomized traffic
// against an integer-arithmetic reference model.
module tb_twos_complement;

    localparam int unsigned W    = 8;
    localparam int          MAXV = (2 ** (W - 1)) - 1;
    localparam int          MINV = -(2 ** (W - 1));
`ifdef TWOS_COMPLEMENT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] data_in;
    logic         out_valid;
    logic [W-1:0] data_out;
    logic         zero;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    // Expected registered state, maintained by the bench.
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_zero;
    logic         exp_ovf;

    twos_complement #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: operate on the signed integer value, then check representability.
    function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] x);
        int v;
        int t;
        int r;
        logic isovf;
        logic [W-1:0] res;
        v = int'($signed(x));
        case (o)
            2'd0:    t = v;
            2'd2:    t = (v < 0) ? -v : v;
            default: t = -v;
        endcase
        isovf = (t > MAXV);
        if (isovf) r = SAT ? MAXV : MINV;
        else       r = t;
        res = W'(r);
        return {res, (res == '0), isovf};
    endfunction

    // Drive one cycle of inputs, advance past the edge, and update expected state.
    task automatic cycle(input logic rst, input logic v, input logic [1:0] o, input logic [W-1:0] d);
        logic [W+1:0] m;
        rst_n    = rst;
        in_valid = v;
        op       = o;
        data_in  = d;
        @(posedge clk);
        if (!rst) begin
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_zero  = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                m = model(o, d);
                exp_data = m[W+1:2];
                exp_zero = m[1];
                exp_ovf  = m[0];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 2'b01, 8'hEB);
            tests++;
            if ({out_valid, data_out, zero, ovf} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset[%0d]: got v=%b d=%h z=%b o=%b, want v=0 d=00 z=0 o=0",
                         i, out_valid, data_out, zero, ovf);
            end
        end
    endtask

    task automatic test_neg_basic();
        logic [W-1:0] ins [3];
        logic [W-1:0] outs[3];
        ins  = '{8'hEB, 8'h5A, 8'h12};
        outs = '{8'h15, 8'hA6, 8'hEE};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 2'b01, ins[i]);
            tests++;
            if ({out_valid, data_out, zero, ovf} !== {1'b1, outs[i], 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL neg_basic[%0d]: got v=%b d=%h z=%b o=%b, want v=1 d=%h z=0 o=0",
                         i, out_valid, data_out, zero, ovf, outs[i]);
            end
        end
    endtask

    task automatic test_zero();
        cycle(1'b1, 1'b1, 2'b01, 8'h00);
        tests++;
        if ({out_valid, data_out, zero, ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL zero: got v=%b d=%h z=%b o=%b, want v=1 d=00 z=1 o=0",
                     out_valid, data_out, zero, ovf);
        end
    endtask

    task automatic test_min();
        logic [W-1:0] want;
        want = SAT ? 8'h7F : 8'h80;
        for (int i = 0; i < 3; i++) begin
            // NEG, NEG alias, ABS all overflow on the most-negative operand.
            cycle(1'b1, 1'b1, (i == 0) ? 2'b01 : (i == 1) ? 2'b11 : 2'b10, 8'h80);
            tests++;
            if ({out_valid, data_out, zero, ovf} !== {1'b1, want, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL min[%0d]: got v=%b d=%h z=%b o=%b, want v=1 d=%h z=0 o=1",
                         i, out_valid, data_out, zero, ovf, want);
            end
        end
        cycle(1'b1, 1'b1, 2'b00, 8'h80);
        tests++;
        if ({data_out, ovf} !== {8'h80, 1'b0}) begin
            fails++;
            $display("FAIL min_pass: got d=%h o=%b, want d=80 o=0", data_out, ovf);
        end
    endtask

    task automatic test_abs_pass();
        logic [1:0]   ops [3];
        logic [W-1:0] ins [3];
        logic [W-1:0] outs[3];
        ops  = '{2'b10, 2'b10, 2'b00};
        ins  = '{8'hEB, 8'h5A, 8'hEB};
        outs = '{8'h15, 8'h5A, 8'hEB};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, ops[i], ins[i]);
            tests++;
            if ({out_valid, data_out, zero, ovf} !== {1'b1, outs[i], 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL abs_pass[%0d]: got v=%b d=%h z=%b o=%b, want v=1 d=%h z=0 o=0",
                         i, out_valid, data_out, zero, ovf, outs[i]);
            end
        end
    endtask

    task automatic test_gap_reset();
        cycle(1'b1, 1'b1, 2'b01, 8'h01);
        tests++;
        if ({out_valid, data_out} !== {1'b1, 8'hFF}) begin
            fails++;
            $display("FAIL gap_valid: got v=%b d=%h, want v=1 d=ff", out_valid, data_out);
        end
        cycle(1'b1, 1'b0, 2'b00, 8'h33);
        tests++;
        if ({out_valid, data_out, zero, ovf} !== {1'b0, 8'hFF, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL gap_idle_hold: got v=%b d=%h z=%b o=%b, want v=0 d=ff z=0 o=0",
                     out_valid, data_out, zero, ovf);
        end
        cycle(1'b0, 1'b1, 2'b01, 8'h80);
        tests++;
        if ({out_valid, data_out, zero, ovf} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL gap_reset: got v=%b d=%h z=%b o=%b, want v=0 d=00 z=0 o=0",
                     out_valid, data_out, zero, ovf);
        end
        cycle(1'b1, 1'b1, 2'b01, 8'h02);
        tests++;
        if ({out_valid, data_out} !== {1'b1, 8'hFE}) begin
            fails++;
            $display("FAIL post_reset: got v=%b d=%h, want v=1 d=fe", out_valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        logic         v;
        logic         r;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 8'h80;
                1:       d = 8'h00;
                2:       d = 8'h7F;
                default: d = W'($urandom);
            endcase
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 49) != 0);
            cycle(r, v, 2'($urandom), d);
            tests++;
            if ({out_valid, data_out, zero, ovf} !== {exp_valid, exp_data, exp_zero, exp_ovf}) begin
                fails++;
                $display("FAIL random[%0d]: got v=%b d=%h z=%b o=%b, want v=%b d=%h z=%b o=%b",
                         i, out_valid, data_out, zero, ovf, exp_valid, exp_data, exp_zero, exp_ovf);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        data_in   = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_zero  = 1'b0;
        exp_ovf   = 1'b0;
        test_reset();
        test_neg_basic();
        test_zero();
        test_min();
        test_abs_pass();
        test_gap_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
